game_ctrl: RTL

- Sequencer and arbiter for the 3x3 board memory (memArray).
- Takes move requests from two players (X and O) over req/ack handshakes and accepts only the player whose turn it is.
- Validates each move against the board state, writes it through memArray's addr/cellState/we port, and detects win or draw after every move.
- Clears the board at game start.

---
 rtl/ttt_pkg.sv | 47 ++++
 rtl/win_check.sv | 25 ++
 rtl/game_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10,
    RSVD  = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    PLAY   = 3'd2,
    WRITE  = 3'd3,
    SETTLE = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam int unsigned N_CELLS = 9;
  localparam int unsigned N_LINES = 8;
  localparam int unsigned BOARD_W = 2 * N_CELLS;

  // Rows, columns, then the two diagonals; cell indices are row-major.
  localparam logic [3:0] WIN_LINES [N_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Cell lookup that never indexes past the board; out-of-range reads EMPTY.
  function automatic cell_t cell_at(input logic [BOARD_W-1:0] board, input logic [3:0] idx);
    cell_t c;
    c = EMPTY;
    for (int i = 0; i < int'(N_CELLS); i++) begin
      if (idx == 4'(i)) c = cell_t'(board[2*i +: 2]);
    end
    return c;
  endfunction

endpackage

// File: rtl/win_check.sv
// Combinational line detector: returns the code owning any full line, else 00.
module win_check
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  output logic [1:0]         winner
);

  cell_t a, b, c;

  // Reserved code never forms a line.
  always_comb begin
    winner = 2'b00;
    a = EMPTY;
    b = EMPTY;
    c = EMPTY;
    for (int i = 0; i < int'(N_LINES); i++) begin
      a = cell_at(board, WIN_LINES[i][0]);
      b = cell_at(board, WIN_LINES[i][1]);
      c = cell_at(board, WIN_LINES[i][2]);
      if ((a == X || a == O) && (a == b) && (a == c)) winner = a;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: clears the board, arbitrates X/O move requests by turn,
// writes accepted moves to memArray and detects win or draw after each move.
module game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0]  FIRST_PLAYER = 2'b01,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               reqX,
  input  logic [3:0]         addrX,
  input  logic               reqO,
  input  logic [3:0]         addrO,
  input  logic [BOARD_W-1:0] gBoard,
  output logic               ackX,
  output logic               ackO,
  output logic               err,
  output logic [3:0]         addr,
  output logic [1:0]         cellState,
  output logic               we,
  output logic [1:0]         turn,
  output logic               gameOver,
  output logic [1:0]         winner
);

  localparam int unsigned SETTLE_W = 2;

  state_t              state;
  cell_t               player;
  logic                accepted;
  logic [3:0]          cell_lat;
  logic [3:0]          move_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [1:0]          line_win;

  logic       cur_req;
  logic [3:0] cur_addr;
  logic       illegal;
  logic       go_clear;

  win_check u_win_check (
    .board  (gBoard),
    .winner (line_win)
  );

  // Only the side to move is ever looked at.
  always_comb begin
    cur_req  = (player == X) ? reqX : reqO;
    cur_addr = (player == X) ? addrX : addrO;
    illegal  = (cur_addr > 4'd8) || (cell_at(gBoard, cur_addr) != EMPTY);
    go_clear = start && (state != CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      player     <= EMPTY;
      accepted   <= 1'b0;
      cell_lat   <= 4'd0;
      move_cnt   <= 4'd0;
      settle_cnt <= '0;
      ackX       <= 1'b0;
      ackO       <= 1'b0;
      err        <= 1'b0;
      addr       <= 4'd0;
      cellState  <= 2'b00;
      we         <= 1'b0;
      turn       <= 2'b00;
      gameOver   <= 1'b0;
      winner     <= 2'b00;
    end else begin
      ackX <= 1'b0;
      ackO <= 1'b0;
      err  <= 1'b0;
      // A start outside CLEAR aborts everything; a WRITE in progress has already issued.
      if (go_clear) begin
        state     <= CLEAR;
        accepted  <= 1'b0;
        we        <= 1'b1;
        addr      <= 4'd0;
        cellState <= 2'b00;
        turn      <= 2'b00;
        gameOver  <= 1'b0;
        winner    <= 2'b00;
      end else begin
        case (state)
          CLEAR: begin
            if (addr == 4'd8) begin
              state     <= PLAY;
              we        <= 1'b0;
              addr      <= 4'd0;
              player    <= cell_t'(FIRST_PLAYER);
              turn      <= FIRST_PLAYER;
              move_cnt  <= 4'd0;
            end else begin
              addr <= addr + 4'd1;
            end
          end
          PLAY: begin
            // The cycle after an accepting ack issues the write.
            if (accepted) begin
              accepted  <= 1'b0;
              state     <= WRITE;
              turn      <= 2'b00;
              we        <= 1'b1;
              addr      <= cell_lat;
              cellState <= player;
              move_cnt  <= move_cnt + 4'd1;
            end else if (cur_req && !ackX && !ackO) begin
              ackX <= (player == X);
              ackO <= (player == O);
              err  <= illegal;
              if (!illegal) begin
                accepted <= 1'b1;
                cell_lat <= cur_addr;
              end
            end
          end
          WRITE: begin
            we         <= 1'b0;
            addr       <= 4'd0;
            cellState  <= 2'b00;
            state      <= SETTLE;
            settle_cnt <= SETTLE_W'(RD_LAT - 1);
          end
          SETTLE: begin
            if (settle_cnt == '0) state <= CHECK;
            else settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
          CHECK: begin
            if (line_win != 2'b00) begin
              winner   <= line_win;
              gameOver <= 1'b1;
              state    <= DONE;
            end else if (move_cnt == 4'(N_CELLS)) begin
              winner   <= 2'b11;
              gameOver <= 1'b1;
              state    <= DONE;
            end else begin
              player <= (player == X) ? O : X;
              turn   <= (player == X) ? 2'(O) : 2'(X);
              state  <= PLAY;
            end
          end
          IDLE, DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
